multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameters: none; operand width fixed at 64 bits.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 mult_type  input  mult_t (4)  operation select from decode control.
REQ-008 src_a, src_b  input  64 each  rs1 and rs2 operand values.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  64  operation result, valid only while out_valid=1.

Function
REQ-012 States: IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 Accept on clk edge with in_valid&in_ready&!flush; operands and mult_type are latched; go to BUSY.
REQ-014 BUSY runs exactly 64 iterations (radix-2 shift-add multiply or restoring divide), then DONE; accept at edge T gives out_valid from cycle T+65.
REQ-015 DONE holds result and out_valid stable until out_ready=1, then returns to IDLE on that edge; no new accept in that same cycle.
REQ-016 MUL: low 64 bits of product; MULH: high 64 bits of signed*signed; MULHSU: high 64 bits of signed(a)*unsigned(b); MULHU: high 64 bits of unsigned*unsigned.
REQ-017 MULW: low 32 bits of a[31:0]*b[31:0], sign-extended to 64.
REQ-018 DIV/REM signed, truncating toward zero; REM takes the sign of the dividend; DIVU/REMU unsigned.
REQ-019 Signed ops compute on magnitudes and apply sign correction at DONE entry.
REQ-020 Divide by zero: DIV/DIVU result = all ones; REM/REMU result = src_a; goes directly to DONE (out_valid at T+1).
REQ-021 Signed overflow (src_a=0x8000_0000_0000_0000, src_b=all ones): DIV result = src_a, REM result = 0; DONE at T+1.
REQ-022 flush=1 in any state: state becomes IDLE and out_valid=0 on the next edge; result is discarded; flush wins over simultaneous in_valid and out_ready.
REQ-023 Undefined mult_type encodings (9-15) produce result 0 with normal 64-iteration latency.

Reset
REQ-024 resetn=0 forces IDLE immediately: in_ready=1, out_valid=0, result=0, iteration counter=0, operand registers cleared.
REQ-025 Reset mid-BUSY or mid-DONE abandons the operation; no result is ever presented for it.

Configuration
REQ-026 Macro MULTDIV_FAST_MUL_EN defined: MUL, MULH, MULHSU, MULHU and MULW use a single-cycle 128-bit product and reach DONE at T+1; divides unchanged.
REQ-027 Macro undefined: all operations use the iterative path per REQ-014; no wide multiplier is instantiated.

Structure
REQ-028 decode_pkg gains multdiv_state_t (IDLE/BUSY/DONE) and constant MULTDIV_ITERS=64; mult_t is reused unchanged.
REQ-029 Restoring divider is a sub-module divider_iter (start, dividend, divisor, unsigned magnitudes, quotient, remainder, done); multiply datapath and sign fix-up stay in multdiv_unit.

Verification
REQ-030 MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid at T+65 (T+1 with MULTDIV_FAST_MUL_EN).
REQ-031 MULHU a=b=all ones -> 0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0; MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-032 DIV a=-7, b=2 -> -3; REM -> -1; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-033 DIV a=5, b=0 -> all ones; REM a=5, b=0 -> 5; DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; all at T+1.
REQ-034 out_ready held 0 for 10 cycles after DONE -> result and out_valid stable; in_valid held high is not accepted until the cycle after the out_ready handshake.
REQ-035 flush at BUSY iteration 30, then resetn pulse during a second BUSY -> IDLE next edge / immediately, out_valid never asserted, following MUL 3*4 returns 12.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - decode-side types shared with the multiply/divide unit
package decode_pkg;

    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHSU = 4'd2,
        MULHU  = 4'd3,
        MULW   = 4'd4,
        DIV    = 4'd5,
        DIVU   = 4'd6,
        REM    = 4'd7,
        REMU   = 4'd8
    } mult_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } multdiv_state_t;

    localparam int unsigned MULTDIV_ITERS = 64;

    function automatic logic is_div_op(input mult_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_mul_op(input mult_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU) || (op == MULW);
    endfunction

    function automatic logic [63:0] abs64(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - 64-iteration restoring divider on unsigned magnitudes
module divider_iter
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        abort,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        done
);

    logic [63:0] r_quo;
    logic [63:0] r_rem;
    logic [63:0] r_dvsr;
    logic [6:0]  r_cnt;
    logic        r_active;

    logic [64:0] w_shifted;
    logic [64:0] w_trial;
    logic        w_last;

    // The quotient register doubles as the dividend shift source.
    assign w_shifted = {r_rem, r_quo[63]};
    assign w_trial   = w_shifted - {1'b0, r_dvsr};
    assign w_last    = (r_cnt == 7'(MULTDIV_ITERS));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quo    <= 64'd0;
            r_rem    <= 64'd0;
            r_dvsr   <= 64'd0;
            r_cnt    <= 7'd0;
            r_active <= 1'b0;
        end else if (abort) begin
            r_cnt    <= 7'd0;
            r_active <= 1'b0;
        end else if (start) begin
            r_quo    <= dividend;
            r_rem    <= 64'd0;
            r_dvsr   <= divisor;
            r_cnt    <= 7'd0;
            r_active <= 1'b1;
        end else if (r_active && !w_last) begin
            if (!w_trial[64]) begin
                r_rem <= w_trial[63:0];
                r_quo <= {r_quo[62:0], 1'b1};
            end else begin
                r_rem <= w_shifted[63:0];
                r_quo <= {r_quo[62:0], 1'b0};
            end
            r_cnt <= r_cnt + 7'd1;
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_active && w_last;

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - 64-bit multiply/divide unit; MULTDIV_FAST_MUL_EN enables single-cycle multiplies
module multdiv_unit
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  mult_t       mult_type,
    input  logic [63:0] src_a,
    input  logic [63:0] src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    multdiv_state_t r_state;
    multdiv_state_t w_state_next;
    mult_t          r_op;
    logic [6:0]     r_cnt;
    logic [127:0]   r_acc;
    logic [63:0]    r_mcand;
    logic [63:0]    r_result;
    logic           r_neg_prod;
    logic           r_neg_quo;
    logic           r_neg_rem;
    logic           r_special;

    logic           w_accept;
    logic           w_done_entry;
    logic           w_is_div;
    logic           w_signed_div;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic           w_special;
    logic           w_neg_prod;
    logic           w_busy_finished;
    logic [63:0]    w_abs_a;
    logic [63:0]    w_abs_b;
    logic [63:0]    w_mcand;
    logic [63:0]    w_mplier;
    logic [63:0]    w_dividend;
    logic [63:0]    w_divisor;
    logic [63:0]    w_special_res;
    logic [63:0]    w_final;
    logic [64:0]    w_sum;
    logic [63:0]    w_quotient;
    logic [63:0]    w_remainder;
    logic           w_div_done;

    function automatic logic [63:0] mul_fixup(input mult_t op, input logic [127:0] prod, input logic neg);
        logic [127:0] signed_prod;
        signed_prod = neg ? (~prod + 128'd1) : prod;
        case (op)
            MUL:          return prod[63:0];
            MULH, MULHSU: return signed_prod[127:64];
            MULHU:        return prod[127:64];
            MULW:         return {{32{prod[31]}}, prod[31:0]};
            default:      return 64'd0;
        endcase
    endfunction

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_is_div  = is_div_op(mult_type);
    assign w_abs_a   = abs64(src_a);
    assign w_abs_b   = abs64(src_b);

    // Multiplies run on magnitudes; the sign is restored when the result is captured.
    always_comb begin
        w_mcand    = src_a;
        w_mplier   = src_b;
        w_neg_prod = 1'b0;
        case (mult_type)
            MULH: begin
                w_mcand    = w_abs_a;
                w_mplier   = w_abs_b;
                w_neg_prod = src_a[63] ^ src_b[63];
            end
            MULHSU: begin
                w_mcand    = w_abs_a;
                w_neg_prod = src_a[63];
            end
            MULW: begin
                w_mcand  = {32'd0, src_a[31:0]};
                w_mplier = {32'd0, src_b[31:0]};
            end
            default: ;
        endcase
    end

    assign w_signed_div = (mult_type == DIV) || (mult_type == REM);
    assign w_dividend   = w_signed_div ? w_abs_a : src_a;
    assign w_divisor    = w_signed_div ? w_abs_b : src_b;
    assign w_div_zero   = (src_b == 64'd0);
    assign w_div_ovf    = w_signed_div && (src_a == INT_MIN) && (src_b == '1);

    always_comb begin
        w_special     = 1'b0;
        w_special_res = 64'd0;
        if (w_is_div && (w_div_zero || w_div_ovf)) begin
            w_special = 1'b1;
            if (w_div_zero) begin
                w_special_res = ((mult_type == DIV) || (mult_type == DIVU)) ? '1 : src_a;
            end else begin
                w_special_res = (mult_type == DIV) ? src_a : 64'd0;
            end
        end
`ifdef MULTDIV_FAST_MUL_EN
        else if (is_mul_op(mult_type)) begin
            w_special     = 1'b1;
            w_special_res = mul_fixup(mult_type, {64'd0, w_mcand} * {64'd0, w_mplier}, w_neg_prod);
        end
`endif
    end

    divider_iter u_divider (
        .clk       (clk),
        .resetn    (resetn),
        .abort     (flush),
        .start     (w_accept && w_is_div && !w_special),
        .dividend  (w_dividend),
        .divisor   (w_divisor),
        .quotient  (w_quotient),
        .remainder (w_remainder),
        .done      (w_div_done)
    );

    // Shift-add step: conditionally add multiplicand to the high half, then shift right.
    assign w_sum = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_mcand} : 65'd0);

    always_comb begin
        w_final = 64'd0;
        case (r_op)
            DIV, DIVU: w_final = r_neg_quo ? (~w_quotient + 64'd1) : w_quotient;
            REM, REMU: w_final = r_neg_rem ? (~w_remainder + 64'd1) : w_remainder;
            default:   w_final = mul_fixup(r_op, r_acc, r_neg_prod);
        endcase
    end

    assign w_busy_finished = r_special ||
                             (is_div_op(r_op) ? w_div_done : (r_cnt == 7'(MULTDIV_ITERS)));

    always_comb begin
        w_state_next = r_state;
        w_done_entry = 1'b0;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (in_valid) w_state_next = BUSY;
                BUSY: begin
                    if (w_busy_finished) begin
                        w_state_next = DONE;
                        w_done_entry = !r_special;
                    end
                end
                DONE: if (out_ready) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_op       <= MUL;
            r_cnt      <= 7'd0;
            r_acc      <= 128'd0;
            r_mcand    <= 64'd0;
            r_result   <= 64'd0;
            r_neg_prod <= 1'b0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_special  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op       <= mult_type;
                r_cnt      <= 7'd0;
                r_acc      <= {64'd0, w_mplier};
                r_mcand    <= w_mcand;
                r_neg_prod <= w_neg_prod;
                r_neg_quo  <= (mult_type == DIV) && (src_a[63] ^ src_b[63]);
                r_neg_rem  <= (mult_type == REM) && src_a[63];
                r_special  <= w_special;
                r_result   <= w_special_res;
            end else if ((r_state == BUSY) && !flush) begin
                if (r_cnt != 7'(MULTDIV_ITERS)) begin
                    r_cnt <= r_cnt + 7'd1;
                    r_acc <= {w_sum, r_acc[63:1]};
                end
                if (w_done_entry) r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit with a behavioural reference model
module tb_multdiv_unit;
    import decode_pkg::*;

`ifdef MULTDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 65;
`endif
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    mult_t       mult_type;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    multdiv_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mult_type (mult_type),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_accept = 0;
    int          hs_edge = 0;
    bit          rnd_bp = 0;
    logic        prev_ov = 1'b0;
    logic [63:0] held = 64'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input int op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  p64;
        longint       sa;
        longint       sb;
        logic         ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MIN64) && (b == ONES);
        case (op)
            0: begin p64 = a * b; return p64; end
            1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4: begin p64 = {32'd0, a[31:0]} * {32'd0, b[31:0]}; return {{32{p64[31]}}, p64[31:0]}; end
            5: begin
                if (b == 0) return ONES;
                if (ovf) return a;
                return sa / sb;
            end
            6: return (b == 0) ? ONES : a / b;
            7: begin
                if (b == 0) return a;
                if (ovf) return 64'd0;
                return sa % sb;
            end
            8: return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lat_model(input int op, input logic [63:0] a, input logic [63:0] b);
        if (op >= 5 && op <= 8 && b == 0) return 1;
        if ((op == 5 || op == 7) && a == MIN64 && b == ONES) return 1;
        if (op <= 4) return MUL_LAT;
        return 65;
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return ONES;
            2: return MIN64;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            5: return {32'd0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic issue(input int op, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input logic [63:0] exp_res, input int exp_lat);
        int n = 0;
        @(negedge clk);
        mult_type = mult_t'(op[3:0]);
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        while (!in_ready && n < 2000) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        last_accept = cyc + 1;
        if (push) sb_q.push_back('{exp_res, exp_lat, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a    = {32'($urandom), 32'($urandom)};
        src_b    = {32'($urandom), 32'($urandom)};
    endtask

    task automatic drain();
        int n = 0;
        if (!rnd_bp) out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < 3000) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(sb_q.size() != 0 || out_valid), 64'd0);
        out_ready = 1'b1;
    endtask

    // Monitor: pops an expectation when a result first appears, then checks it holds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result", result, e.res);
                        chk("latency", 64'(cyc - e.acc_edge), 64'(e.lat));
                    end
                    held = result;
                end else if (out_valid && prev_ov) begin
                    chk("result_stable", result, held);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mult_type = MUL;
        src_a     = 64'd0;
        src_b     = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        resetn = 1'b1;

        issue(0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        issue(3, ONES, ONES, 1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
        issue(1, ONES, ONES, 1, 64'd0, MUL_LAT);
        issue(4, 64'h7FFF_FFFF, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
        issue(5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        issue(7, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, ONES, 65);
        issue(6, 64'd100, 64'd7, 1, 64'd14, 65);
        issue(8, 64'd100, 64'd7, 1, 64'd2, 65);
        issue(5, 64'd5, 64'd0, 1, ONES, 1);
        issue(7, 64'd5, 64'd0, 1, 64'd5, 1);
        issue(5, MIN64, ONES, 1, MIN64, 1);
        issue(12, 64'd9, 64'd9, 1, 64'd0, 65);
        drain();

        rnd_bp = 1;
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [63:0] a;
            logic [63:0] b;
            op = $urandom_range(0, 11);
            a  = pick64();
            b  = pick64();
            issue(op, a, b, 1, model(op, a, b), lat_model(op, a, b));
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
        end
        drain();
        rnd_bp = 0;

        out_ready = 1'b0;
        issue(6, 64'd100, 64'd7, 1, 64'd14, 65);
        fork
            issue(0, 64'd3, 64'd5, 1, 64'd15, MUL_LAT);
            begin
                int n = 0;
                while (!out_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                hs_edge   = cyc + 1;
            end
        join
        chk("accept_after_handshake", 64'(last_accept), 64'(hs_edge + 1));
        drain();

        issue(0, 64'd3, 64'd4, 0, 64'd0, 0);
        repeat (30) @(negedge clk);
        chk("busy_before_flush", 64'(in_ready), 64'(MUL_LAT == 1 ? 1 : 0));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        issue(6, 64'd100, 64'd7, 0, 64'd0, 0);
        repeat (20) @(negedge clk);
        chk("busy_before_reset", 64'(in_ready), 64'd0);
        resetn = 1'b0;
        #1;
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (70) begin
            @(negedge clk);
            chk("no_abandoned_result", 64'(out_valid), 64'd0);
        end
        issue(0, 64'd3, 64'd4, 1, 64'd12, MUL_LAT);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
